// File: rtl/alu_issue.sv
// alu_issue: decodes RV32I ALU instructions (R-type, I-type ALU, LUI) into an
// ALU function code plus final operands, then buffers them in a 2-entry
// in-order FIFO. The execute side sees the head entry directly from a register.
module alu_issue #(
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_inst,
  input  logic [DataWidth-1:0] in_rs1_data,
  input  logic [DataWidth-1:0] in_rs2_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           out_func,
  output logic [DataWidth-1:0] out_op1,
  output logic [DataWidth-1:0] out_op2,
  output logic [4:0]           out_rd,
  output logic                 out_wen,
  output logic                 out_illegal,
  output logic                 err_sticky
);

  localparam logic [3:0] FuncZero = 4'd0;
  localparam logic [3:0] FuncAdd  = 4'd1;
  localparam logic [3:0] FuncSub  = 4'd2;
  localparam logic [3:0] FuncSll  = 4'd3;
  localparam logic [3:0] FuncSlt  = 4'd4;
  localparam logic [3:0] FuncXor  = 4'd5;
  localparam logic [3:0] FuncOr   = 4'd6;
  localparam logic [3:0] FuncAnd  = 4'd7;
  localparam logic [3:0] FuncSrl  = 4'd8;
  localparam logic [3:0] FuncSra  = 4'd9;
  localparam logic [3:0] FuncSltu = 4'd10;

  localparam logic [6:0] OpReg = 7'b0110011;
  localparam logic [6:0] OpImm = 7'b0010011;
  localparam logic [6:0] OpLui = 7'b0110111;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  typedef struct packed {
    logic [3:0]           func;
    logic [DataWidth-1:0] op1;
    logic [DataWidth-1:0] op2;
    logic [4:0]           rd;
    logic                 wen;
    logic                 illegal;
  } entry_t;

  logic [6:0]           opcode;
  logic [6:0]           funct7;
  logic [2:0]           funct3;
  logic [DataWidth-1:0] imm_sext;
  logic [DataWidth-1:0] shamt;
  logic [DataWidth-1:0] lui_imm;

  assign opcode   = in_inst[6:0];
  assign funct3   = in_inst[14:12];
  assign funct7   = in_inst[31:25];
  assign imm_sext = DataWidth'($signed(in_inst[31:20]));
  assign shamt    = DataWidth'(in_inst[24:20]);
  assign lui_imm  = DataWidth'({in_inst[31:12], 12'b0});

  entry_t               dec;
  logic                 dec_legal;
  logic [3:0]           dec_func;
  logic [DataWidth-1:0] dec_op1;
  logic [DataWidth-1:0] dec_op2;

  // Decode the incoming instruction into a FIFO entry.
  always_comb begin
    dec_legal = 1'b0;
    dec_func  = FuncZero;
    dec_op1   = '0;
    dec_op2   = '0;
    case (opcode)
      OpReg: begin
        dec_op1 = in_rs1_data;
        dec_op2 = in_rs2_data;
        if (funct7 == F7Base) begin
          dec_legal = 1'b1;
          case (funct3)
            3'b000:  dec_func = FuncAdd;
            3'b001:  dec_func = FuncSll;
            3'b010:  dec_func = FuncSlt;
            3'b011:  dec_func = FuncSltu;
            3'b100:  dec_func = FuncXor;
            3'b101:  dec_func = FuncSrl;
            3'b110:  dec_func = FuncOr;
            default: dec_func = FuncAnd;
          endcase
        end else if (funct7 == F7Alt) begin
          if (funct3 == 3'b000) begin
            dec_legal = 1'b1;
            dec_func  = FuncSub;
          end else if (funct3 == 3'b101) begin
            dec_legal = 1'b1;
            dec_func  = FuncSra;
          end
        end
      end
      OpImm: begin
        dec_op1 = in_rs1_data;
        dec_op2 = imm_sext;
        case (funct3)
          3'b000: begin dec_legal = 1'b1; dec_func = FuncAdd;  end
          3'b010: begin dec_legal = 1'b1; dec_func = FuncSlt;  end
          3'b011: begin dec_legal = 1'b1; dec_func = FuncSltu; end
          3'b100: begin dec_legal = 1'b1; dec_func = FuncXor;  end
          3'b110: begin dec_legal = 1'b1; dec_func = FuncOr;   end
          3'b111: begin dec_legal = 1'b1; dec_func = FuncAnd;  end
          3'b001: begin
            dec_op2 = shamt;
            if (funct7 == F7Base) begin
              dec_legal = 1'b1;
              dec_func  = FuncSll;
            end
          end
          default: begin
            dec_op2 = shamt;
            if (funct7 == F7Base) begin
              dec_legal = 1'b1;
              dec_func  = FuncSrl;
            end else if (funct7 == F7Alt) begin
              dec_legal = 1'b1;
              dec_func  = FuncSra;
            end
          end
        endcase
      end
      OpLui: begin
        dec_legal = 1'b1;
        dec_func  = FuncAdd;
        dec_op1   = '0;
        dec_op2   = lui_imm;
      end
      default: ;
    endcase

    // Illegal entries carry no operands so the ALU computes nothing meaningful.
    dec.func    = dec_legal ? dec_func : FuncZero;
    dec.op1     = dec_legal ? dec_op1 : '0;
    dec.op2     = dec_legal ? dec_op2 : '0;
    dec.rd      = in_inst[11:7];
    dec.wen     = dec_legal && (in_inst[11:7] != 5'd0);
    dec.illegal = !dec_legal;
  end

  entry_t     head_q, head_d;
  entry_t     tail_q, tail_d;
  logic [1:0] count_q, count_d;
  logic       err_q, err_d;
  logic       push, pop;

  assign in_ready  = !rst && (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // FIFO next state: head is the output register, tail holds the second entry.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = err_q || (push && dec.illegal);
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d = dec;
        end else begin
          tail_d = dec;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        // Popping the last entry leaves head untouched so outputs hold their value.
        if (count_q == 2'd2) begin
          head_d = tail_q;
        end
        count_d = count_q - 2'd1;
      end
      // Push with pop only happens at count 1: new entry replaces the retired head.
      2'b11: head_d = dec;
      default: ;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign out_func    = head_q.func;
  assign out_op1     = head_q.op1;
  assign out_op2     = head_q.op2;
  assign out_rd      = head_q.rd;
  assign out_wen     = head_q.wen;
  assign out_illegal = head_q.illegal;
  assign err_sticky  = err_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic [31:0] in_rs1_data = '0;
  logic [31:0] in_rs2_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_func;
  logic [31:0] out_op1;
  logic [31:0] out_op2;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        out_illegal;
  logic        err_sticky;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0]  func;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        wen;
    logic        ill;
  } ent_t;

  ent_t q[$];
  ent_t last_head = '0;
  logic m_sticky = 1'b0;
  ent_t obs;

  assign obs = {out_func, out_op1, out_op2, out_rd, out_wen, out_illegal};

  alu_issue #(.DataWidth(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .in_rs1_data (in_rs1_data),
    .in_rs2_data (in_rs2_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_func    (out_func),
    .out_op1     (out_op1),
    .out_op2     (out_op2),
    .out_rd      (out_rd),
    .out_wen     (out_wen),
    .out_illegal (out_illegal),
    .err_sticky  (err_sticky)
  );

  always #5 clk = ~clk;

  // Reference decode from the instruction-set rules.
  function automatic ent_t ref_decode(input logic [31:0] inst, input logic [31:0] rs1,
                                      input logic [31:0] rs2);
    ent_t        e;
    logic [3:0]  base[8] = '{4'd1, 4'd3, 4'd4, 4'd10, 4'd5, 4'd8, 4'd6, 4'd7};
    int unsigned f3 = inst[14:12];
    int unsigned f7 = inst[31:25];
    int unsigned imm = inst[31:20];
    bit          ok = 0;
    e = '0;
    case (inst[6:0])
      7'h33: begin
        e.op1 = rs1;
        e.op2 = rs2;
        if (f7 == 0) begin ok = 1; e.func = base[f3]; end
        else if (f7 == 32 && f3 == 0) begin ok = 1; e.func = 4'd2; end
        else if (f7 == 32 && f3 == 5) begin ok = 1; e.func = 4'd9; end
      end
      7'h13: begin
        e.op1 = rs1;
        if (f3 == 1 || f3 == 5) begin
          e.op2 = 32'(inst[24:20]);
          if (f7 == 0) begin ok = 1; e.func = base[f3]; end
          else if (f3 == 5 && f7 == 32) begin ok = 1; e.func = 4'd9; end
        end else begin
          ok = 1;
          e.func = base[f3];
          e.op2 = (imm >= 2048) ? imm - 4096 : imm;
        end
      end
      7'h37: begin
        ok = 1;
        e.func = 4'd1;
        e.op2 = 32'(inst[31:12]) * 4096;
      end
      default: ;
    endcase
    if (!ok) begin
      e = '0;
      e.ill = 1'b1;
    end
    e.rd = inst[11:7];
    e.wen = ok && (inst[11:7] != 5'd0);
    return e;
  endfunction

  function automatic ent_t exp_head();
    return (q.size() > 0) ? q[0] : last_head;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r = $urandom();
    logic [6:0]  f7;
    case ($urandom_range(0, 2))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      default: f7 = r[31:25];
    endcase
    case ($urandom_range(0, 5))
      0: return {f7, r[24:7], 7'h33};
      1: return {r[31:7], 7'h13};
      2: return {f7, r[24:15], (r[0] ? 3'b101 : 3'b001), r[11:7], 7'h13};
      3: return {r[31:7], 7'h37};
      4: return r;
      default: return {r[31:7], 7'h73};
    endcase
  endfunction

  // One clock: drive inputs, advance the model at the edge, return at the negedge.
  task automatic cycle(input logic r, input logic v, input logic [31:0] inst,
                       input logic [31:0] a, input logic [31:0] b, input logic rdy);
    bit push, pop;
    rst = r;
    in_valid = v;
    in_inst = inst;
    in_rs1_data = a;
    in_rs2_data = b;
    out_ready = rdy;
    push = !r && v && (q.size() < 2);
    pop = !r && (q.size() > 0) && rdy;
    @(posedge clk);
    if (r) begin
      q.delete();
      last_head = '0;
      m_sticky = 1'b0;
    end else begin
      if (pop) last_head = q.pop_front();
      if (push) begin
        ent_t e = ref_decode(inst, a, b);
        q.push_back(e);
        if (e.ill) m_sticky = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_inst = 32'h002081B3;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL reset_ready: got %b want 0", in_ready);
    end
    cycle(1, 1, 32'h002081B3, 5, 7, 1);
    cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== '0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out: got %h valid %b want 0", obs, out_valid);
    end
    checks++;
    if (in_ready !== 1'b1 || err_sticky !== 1'b0) begin
      failures++; $display("FAIL reset_ctrl: ready %b sticky %b want 1 0", in_ready, err_sticky);
    end
  endtask

  task automatic test_alu_ops();
    logic [31:0] insts[5] = '{32'h002081B3, 32'h402081B3, 32'hFFF00293, 32'h4040D093,
                              32'h123453B7};
    logic [31:0] rs1s[5] = '{32'd5, 32'd5, 32'd0, 32'h80000000, 32'd0};
    logic [31:0] rs2s[5] = '{32'd7, 32'd7, 32'd0, 32'd0, 32'd0};
    logic [3:0]  efunc[5] = '{4'd1, 4'd2, 4'd1, 4'd9, 4'd1};
    logic [31:0] eop1[5] = '{32'd5, 32'd5, 32'd0, 32'h80000000, 32'd0};
    logic [31:0] eop2[5] = '{32'd7, 32'd7, 32'hFFFFFFFF, 32'd4, 32'h12345000};
    logic [4:0]  erd[5] = '{5'd3, 5'd3, 5'd5, 5'd1, 5'd7};
    ent_t        want;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, insts[i], rs1s[i], rs2s[i], 1);
      want = {efunc[i], eop1[i], eop2[i], erd[i], 1'b1, 1'b0};
      checks++;
      if (out_valid !== 1'b1 || obs !== want) begin
        failures++;
        $display("FAIL alu_op%0d: valid %b got %h want %h", i, out_valid, obs, want);
      end
    end
    cycle(0, 0, 0, 0, 0, 1);
    checks++;
    if (out_valid !== 1'b0 || obs !== want) begin
      failures++; $display("FAIL hold_last: valid %b got %h want %h", out_valid, obs, want);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] inst = 32'h00108093;
    int          got[$];
    bit          cpend = 1;
    cycle(0, 1, inst, 32'h11, 0, 0);
    cycle(0, 1, inst, 32'h22, 0, 0);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_op1 !== 32'h11) begin
      failures++;
      $display("FAIL bp_full: ready %b valid %b op1 %h want 0 1 11", in_ready, out_valid, out_op1);
    end
    cycle(0, 1, inst, 32'h33, 0, 0);
    checks++;
    if (in_ready !== 1'b0 || out_op1 !== 32'h11 || out_op2 !== 32'd1) begin
      failures++;
      $display("FAIL bp_stable: ready %b op1 %h op2 %h want 0 11 1", in_ready, out_op1, out_op2);
    end
    for (int k = 0; k < 8; k++) begin
      bit acc;
      if (out_valid === 1'b1) got.push_back(int'(out_op1));
      acc = cpend && (in_ready === 1'b1);
      cycle(0, cpend, inst, 32'h33, 0, 1);
      if (acc) cpend = 0;
      if (k == 0) begin
        checks++;
        if (in_ready !== 1'b1) begin
          failures++; $display("FAIL bp_ready_after_pop: got %b want 1", in_ready);
        end
      end
    end
    checks++;
    if (got.size() != 3) begin
      failures++; $display("FAIL bp_count: got %0d want 3", got.size());
    end else begin
      checks++;
      if (got[0] != 32'h11 || got[1] != 32'h22 || got[2] != 32'h33) begin
        failures++;
        $display("FAIL bp_order: got %h %h %h want 11 22 33", got[0], got[1], got[2]);
      end
    end
  endtask

  task automatic test_illegal();
    cycle(0, 1, 32'h00000073, 9, 9, 0);
    checks++;
    if (out_valid !== 1'b1 || obs !== {4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1}) begin
      failures++; $display("FAIL ecall: valid %b got %h want illegal entry", out_valid, obs);
    end
    checks++;
    if (err_sticky !== 1'b1) begin
      failures++; $display("FAIL ecall_sticky: got %b want 1", err_sticky);
    end
    cycle(0, 1, 32'h00000013, 0, 0, 1);
    checks++;
    if (out_valid !== 1'b1 || out_wen !== 1'b0 || out_illegal !== 1'b0 || out_func !== 4'd1) begin
      failures++;
      $display("FAIL nop: wen %b ill %b func %0d want 0 0 1", out_wen, out_illegal, out_func);
    end
    repeat (3) cycle(0, 0, 0, 0, 0, 1);
    checks++;
    if (err_sticky !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL sticky_hold: sticky %b valid %b want 1 0", err_sticky, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    cycle(0, 1, 32'h00000073, 1, 1, 0);
    cycle(0, 1, 32'h002081B3, 2, 3, 0);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL mid_full: ready %b want 0", in_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL mid_rst_ready: got %b want 0", in_ready);
    end
    cycle(1, 1, 32'h002081B3, 4, 4, 1);
    checks++;
    if (out_valid !== 1'b0 || obs !== '0 || err_sticky !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst_out: valid %b got %h sticky %b want 0", out_valid, obs, err_sticky);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL mid_post_ready: got %b want 1", in_ready);
    end
    cycle(0, 1, 32'h002081B3, 5, 7, 0);
    checks++;
    if (out_valid !== 1'b1 || obs !== {4'd1, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0}) begin
      failures++; $display("FAIL mid_first_push: valid %b got %h", out_valid, obs);
    end
    cycle(0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_random();
    bit          hold = 0;
    logic        v = 0;
    logic [31:0] inst = '0, a = '0, b = '0;
    for (int n = 0; n < 600; n++) begin
      ent_t exp_e;
      logic r, rdy, exp_ready;
      exp_e = exp_head();
      exp_ready = !rst && (q.size() < 2);
      checks++;
      if (in_ready !== exp_ready || out_valid !== (q.size() > 0)) begin
        failures++;
        $display("FAIL rnd_hs cycle %0d: ready %b valid %b want %b %b", n, in_ready, out_valid,
                 exp_ready, q.size() > 0);
      end
      checks++;
      if (obs !== exp_e || err_sticky !== m_sticky) begin
        failures++;
        $display("FAIL rnd_out cycle %0d: got %h sticky %b want %h %b", n, obs, err_sticky,
                 exp_e, m_sticky);
      end
      r = ($urandom_range(0, 49) == 0);
      if (!hold) begin
        v = ($urandom_range(0, 3) != 0);
        inst = rand_inst();
        a = $urandom();
        b = $urandom();
      end
      rdy = ($urandom_range(0, 3) != 0);
      hold = v && !r && (q.size() >= 2);
      cycle(r, v, inst, a, b, rdy);
    end
    cycle(0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Decode-and-issue stage placed in front of the integer ALU in the CPU datapath. It accepts instruction words with their register operands over a valid/ready handshake. It decodes R-type, I-type ALU and LUI instructions into the 4-bit ALU function code and final operands, and buffers the decoded entries in a 2-entry FIFO. Entries are presented to the ALU/execute side over a second valid/ready handshake.

## Interface
- DataWidth, 32, operand width (decode logic is defined for 32).
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry.
- in_inst  in  32  RV32I instruction word.
- in_rs1_data  in  DataWidth  rs1 register value.
- in_rs2_data  in  DataWidth  rs2 register value.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream consumes head.
- out_func  out  4  ALU code: ZERO=0, ADD=1, SUB=2, SLL=3, SLT=4, XOR=5, OR=6, AND=7, SRL=8, SRA=9, SLTU=10.
- out_op1  out  DataWidth  ALU operand 1.
- out_op2  out  DataWidth  ALU operand 2.
- out_rd  out  5  destination register, inst[11:7].
- out_wen  out  1  register writeback enable.
- out_illegal  out  1  head entry is an unsupported instruction.
- err_sticky  out  1  set when any illegal entry is accepted; cleared only by rst.

## Operation
- Accept when in_valid && in_ready. Pop when out_valid && out_ready.
- Decode happens at accept. The decoded entry is written into the FIFO tail.
- Opcode 0110011 (R-type): op1=rs1, op2=rs2.
  - funct7=0000000: funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - funct7=0100000: funct3 000 SUB, 101 SRA.
  - Any other funct7/funct3 combination is illegal.
- Opcode 0010011 (I-type): op1=rs1, op2 = sign-extended inst[31:20].
  - funct3 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
  - funct3 001 with inst[31:25]=0 is SLL.
  - funct3 101 with inst[31:25]=0 is SRL; with inst[31:25]=0100000 it is SRA.
  - Shift forms use op2 = zero-extended inst[24:20].
  - Any other shift encoding is illegal.
- Opcode 0110111 (LUI): func=ADD, op1=0, op2={inst[31:12],12'b0}.
- All other opcodes are illegal.
- Illegal entry: func=ZERO, op1=op2=0, wen=0, illegal=1; err_sticky set on accept.
- Legal entry: wen = (rd != 0), illegal=0.
- FIFO: 2 entries, in-order, count 0..2.
  - in_ready = !rst && count<2.
  - out_valid = count>0.
  - Output fields come from the head register. When out_valid=0 they hold their last value (ZERO/0 after reset).

## Timing
- Latency: an entry accepted in cycle N is visible on out_* in cycle N+1 at the earliest. There is no combinational in->out bypass.
- in_ready depends only on registered count and rst, never on out_ready.
- Push and pop in the same cycle at count=1: count stays 1. The new entry becomes head at N+1, and the old head is retired.
- count=2: in_ready=0, so no push is possible; a pop drops count to 1, and in_ready=1 the next cycle.
- count=0 with push: count becomes 1; no pop is possible in that cycle.
- Outputs are stable while out_valid && !out_ready. Handshake rules:
  - Upstream must hold in_* stable while in_valid && !in_ready.
  - The stage never drops in_valid-qualified data.
- rst asserted in any cycle, including mid-transfer:
  - Next cycle: count=0, out_valid=0, out_func=0, op1/op2/rd=0, wen=0, out_illegal=0, err_sticky=0.
  - While rst=1: in_ready=0, and no accept occurs.

## Test plan
- add x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, func=1, op1=5, op2=7, rd=3, wen=1.
- sub (0x402081B3) with rs1=5, rs2=7 -> func=2. addi x5,x0,-1 (0xFFF00293), rs1=0 -> func=1, op1=0, op2=0xFFFFFFFF, rd=5.
- srai x1,x1,4 (0x4040D093), rs1=0x80000000 -> func=9, op2=4. lui x7,0x12345 (0x123453B7) -> func=1, op1=0, op2=0x12345000, wen=1.
- Backpressure: out_ready=0, three back-to-back valid entries A,B,C -> in_ready=0 after A and B are accepted; C is held. Then out_ready=1 -> A, B, C emitted in order, one per cycle, with no loss or duplication.
- Illegal: ecall (0x00000073) -> func=0, wen=0, out_illegal=1, err_sticky=1 and held. addi x0,x0,0 -> wen=0, illegal=0.
- rst pulse with count=2 -> next cycle out_valid=0, in_ready=1, err_sticky=0. An entry pushed immediately after reset appears one cycle later.
